alu_pipelined_unit: RTL and testbench

Parametrised successor to the single-cycle integer ALU execution unit. It supports configurable data width and a configurable number of result pipeline stages (1..3) for timing closure. A result buffer holds completed results so the unit can absorb writeback backpressure instead of assuming a same-cycle commit. It sits between issue and writeback, and takes pre-decoded control registered in decode.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_result_fifo.sv | 46 ++++
 rtl/alu_pipelined_unit.sv | 156 +++++++++++++++
 tb/tb_alu_pipelined_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode and logic-op encodings plus the decoded control bundle.
// The ALU_SHADD_EN build reuses the ALU_SHADD encoding declared here.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_CONSTANT  = 3'd0,
        ALU_ADD_SUB   = 3'd1,
        ALU_SLT_LOGIC = 3'd2,
        ALU_SHIFT     = 3'd3,
        ALU_SHADD     = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        LOGIC_XOR   = 2'd0,
        LOGIC_OR    = 2'd1,
        LOGIC_AND   = 2'd2,
        LOGIC_OTHER = 2'd3
    } logic_op_t;

    typedef struct packed {
        alu_op_t   op;
        logic_op_t logic_op;
        logic      subtract;
        logic      is_slt;
        logic      is_unsigned;
        logic      shift_left;
        logic      shift_arith;
        logic      use_imm;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Circular result buffer with registered storage; head data reads as zero while empty.
// DEPTH must be a power of two and at least 2.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign head_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_pipelined_unit.sv
// Pipelined integer ALU: combinational execute, LATENCY result stages, credit-controlled result buffer.
// Defining ALU_SHADD_EN adds the shadd_amt port and Zba shift-and-add on the ALU_SHADD opcode.
module alu_pipelined_unit
    import alu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LATENCY      = 1,
    parameter int RESULT_DEPTH = 4,
    parameter int ID_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [ID_W-1:0]  issue_id,
    input  alu_op_t          op,
    input  logic_op_t        logic_op,
    input  logic             subtract,
    input  logic             is_slt,
    input  logic             is_unsigned,
    input  logic             shift_left,
    input  logic             shift_arith,
    input  logic             use_imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  constant,
`ifdef ALU_SHADD_EN
    input  logic [1:0]       shadd_amt,
`endif
    output logic             wb_done,
    output logic [ID_W-1:0]  wb_id,
    output logic [XLEN-1:0]  wb_rd,
    input  logic             wb_ack
);

    localparam int SHW   = $clog2(XLEN);
    localparam int OCC_W = $clog2(RESULT_DEPTH) + 1;

    alu_ctrl_t              w_ctrl;
    logic [XLEN-1:0]        w_b;
    logic [XLEN:0]          w_a_ext;
    logic [XLEN:0]          w_b_ext;
    logic [XLEN:0]          w_sum;
    logic [SHW-1:0]         w_shamt;
    logic [XLEN-1:0]        w_shl;
    logic signed [XLEN:0]   w_shr_src;
    logic [XLEN-1:0]        w_shr;
    logic [XLEN-1:0]        w_result;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [ID_W+XLEN-1:0]   w_head;

    logic [LATENCY-1:0]     r_v;
    logic [ID_W-1:0]        r_id [LATENCY];
    logic [XLEN-1:0]        r_rd [LATENCY];
    logic [OCC_W-1:0]       r_occ;

    assign w_ctrl = '{op: op, logic_op: logic_op, subtract: subtract, is_slt: is_slt,
                      is_unsigned: is_unsigned, shift_left: shift_left,
                      shift_arith: shift_arith, use_imm: use_imm};

    // The adder is one bit wider so bit XLEN is the signed/unsigned less-than flag.
    assign w_b       = w_ctrl.use_imm ? imm : rs2;
    assign w_a_ext   = {~w_ctrl.is_unsigned & rs1[XLEN-1], rs1};
    assign w_b_ext   = {~w_ctrl.is_unsigned & w_b[XLEN-1], w_b};
    assign w_sum     = w_a_ext + (w_ctrl.subtract ? ~w_b_ext : w_b_ext)
                       + {{XLEN{1'b0}}, w_ctrl.subtract};
    assign w_shamt   = w_b[SHW-1:0];
    assign w_shl     = rs1 << w_shamt;
    assign w_shr_src = {w_ctrl.shift_arith & rs1[XLEN-1], rs1};
    assign w_shr     = XLEN'(w_shr_src >>> w_shamt);

    always_comb begin
        w_result = '0;
        case (w_ctrl.op)
            ALU_CONSTANT: w_result = constant;
`ifdef ALU_SHADD_EN
            ALU_ADD_SUB:  w_result = w_sum[XLEN-1:0];
            ALU_SHADD:    w_result = (rs1 << shadd_amt) + rs2;
`else
            ALU_ADD_SUB, ALU_SHADD: w_result = w_sum[XLEN-1:0];
`endif
            ALU_SLT_LOGIC: begin
                if (w_ctrl.is_slt) begin
                    w_result = {{(XLEN-1){1'b0}}, w_sum[XLEN]};
                end else begin
                    case (w_ctrl.logic_op)
                        LOGIC_XOR: w_result = rs1 ^ w_b;
                        LOGIC_OR:  w_result = rs1 | w_b;
                        LOGIC_AND: w_result = rs1 & w_b;
                        default:   w_result = w_sum[XLEN-1:0];
                    endcase
                end
            end
            ALU_SHIFT: begin
                if (w_ctrl.shift_left) w_result = w_shl;
                else                   w_result = w_shr;
            end
            default: w_result = '0;
        endcase
    end

    // Result stages shift every cycle; no stall is ever needed because credits reserve buffer space.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_id[i] <= '0;
                r_rd[i] <= '0;
            end
        end else begin
            r_v[0] <= w_accept;
            if (w_accept) begin
                r_id[0] <= issue_id;
                r_rd[0] <= w_result;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_v[i]  <= r_v[i-1];
                r_id[i] <= r_id[i-1];
                r_rd[i] <= r_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                       r_occ <= '0;
        else if (w_accept && !w_pop)   r_occ <= r_occ + OCC_W'(1);
        else if (!w_accept && w_pop)   r_occ <= r_occ - OCC_W'(1);
        else                           r_occ <= r_occ;
    end

    assign issue_ready = (r_occ < OCC_W'(RESULT_DEPTH)) && !w_full;
    assign w_accept    = issue_valid & issue_ready;
    assign w_pop       = wb_ack & wb_done;
    assign wb_done     = ~w_empty;
    assign wb_id       = w_head[ID_W+XLEN-1:XLEN];
    assign wb_rd       = w_head[XLEN-1:0];

    alu_result_fifo #(
        .DEPTH (RESULT_DEPTH),
        .WIDTH (ID_W + XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_v[LATENCY-1]),
        .push_data ({r_id[LATENCY-1], r_rd[LATENCY-1]}),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (w_head)
    );

endmodule

// File: tb/tb_alu_pipelined_unit.sv
// Directed bench: a 32-bit LATENCY=2 unit for vectors, ordering, backpressure and reset,
// plus a 64-bit LATENCY=1 unit for wide-datapath cases.
module tb_alu_pipelined_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v32, v64, ack32, ack64;
    logic [2:0]  id;
    alu_op_t     op;
    logic_op_t   lop;
    logic        sub, slt, uns, shl, sha, uimm;
    logic [63:0] a, b, im, cst;
    logic        ready32, done32, ready64, done64;
    logic [2:0]  wid32, wid64;
    logic [31:0] wrd32;
    logic [63:0] wrd64;
`ifdef ALU_SHADD_EN
    logic [1:0]  shadd_amt;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [2:0] got [$];

    always #5 clk = ~clk;

    alu_pipelined_unit #(.XLEN(32), .LATENCY(2), .RESULT_DEPTH(4), .ID_W(3)) dut32 (
        .clk(clk), .rst(rst), .issue_valid(v32), .issue_ready(ready32), .issue_id(id),
        .op(op), .logic_op(lop), .subtract(sub), .is_slt(slt), .is_unsigned(uns),
        .shift_left(shl), .shift_arith(sha), .use_imm(uimm),
        .rs1(a[31:0]), .rs2(b[31:0]), .imm(im[31:0]), .constant(cst[31:0]),
`ifdef ALU_SHADD_EN
        .shadd_amt(shadd_amt),
`endif
        .wb_done(done32), .wb_id(wid32), .wb_rd(wrd32), .wb_ack(ack32));

    alu_pipelined_unit #(.XLEN(64), .LATENCY(1), .RESULT_DEPTH(4), .ID_W(3)) dut64 (
        .clk(clk), .rst(rst), .issue_valid(v64), .issue_ready(ready64), .issue_id(id),
        .op(op), .logic_op(lop), .subtract(sub), .is_slt(slt), .is_unsigned(uns),
        .shift_left(shl), .shift_arith(sha), .use_imm(uimm),
        .rs1(a), .rs2(b), .imm(im), .constant(cst),
`ifdef ALU_SHADD_EN
        .shadd_amt(shadd_amt),
`endif
        .wb_done(done64), .wb_id(wid64), .wb_rd(wrd64), .wb_ack(ack64));

    typedef struct {
        alu_op_t     op;
        logic_op_t   lop;
        logic [5:0]  flags;   // {sub, slt, uns, shl, sha, uimm}
        logic [31:0] rs1, rs2, imm, cst, exp;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(alu_op_t o, logic_op_t l, logic [5:0] f,
                                logic [31:0] r1, logic [31:0] r2, logic [31:0] i, logic [31:0] c,
                                logic [31:0] e);
        vec_t v;
        v.op = o; v.lop = l; v.flags = f; v.rs1 = r1; v.rs2 = r2; v.imm = i; v.cst = c; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Records the head id whenever this edge will pop it, then steps one cycle.
    task automatic tk();
        if (done32 && ack32) got.push_back(wid32);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input alu_op_t o, input logic_op_t l, input logic [5:0] f,
                            input logic [63:0] r1, input logic [63:0] r2,
                            input logic [63:0] i, input logic [63:0] c);
        op = o; lop = l; {sub, slt, uns, shl, sha, uimm} = f;
        a = r1; b = r2; im = i; cst = c;
    endtask

    task automatic run32(input string nm, input logic [31:0] exp, input logic [2:0] idv);
        int w;
        id = idv; v32 = 1'b1;
        tk();
        v32 = 1'b0;
        w = 0;
        while (!done32 && w < 10) begin tk(); w++; end
        chk({nm, "_done"}, {63'd0, done32}, 64'd1);
        chk(nm, {32'd0, wrd32}, {32'd0, exp});
        chk({nm, "_id"}, {61'd0, wid32}, {61'd0, idv});
        tk();
    endtask

    task automatic run64(input string nm, input logic [63:0] exp);
        int w;
        id = 3'd6; v64 = 1'b1;
        tk();
        v64 = 1'b0;
        w = 0;
        while (!done64 && w < 10) begin tk(); w++; end
        chk({nm, "_done"}, {63'd0, done64}, 64'd1);
        chk(nm, wrd64, exp);
        chk({nm, "_id"}, {61'd0, wid64}, 64'd6);
        tk();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(ALU_ADD_SUB,   LOGIC_XOR, 6'b000000, 32'd5,          32'd7,          32'd0,          32'd0, 32'd12);
        vecs[1]  = mk(ALU_ADD_SUB,   LOGIC_XOR, 6'b100000, 32'd10,         32'd3,          32'd0,          32'd0, 32'd7);
        vecs[2]  = mk(ALU_ADD_SUB,   LOGIC_XOR, 6'b000001, 32'd100,        32'd55,         32'hFFFF_FFFF,  32'd0, 32'd99);
        vecs[3]  = mk(ALU_SLT_LOGIC, LOGIC_XOR, 6'b110000, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0, 32'd1);
        vecs[4]  = mk(ALU_SLT_LOGIC, LOGIC_XOR, 6'b111000, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0, 32'd0);
        vecs[5]  = mk(ALU_SHIFT,     LOGIC_XOR, 6'b000010, 32'h8000_0000,  32'd4,          32'd0,          32'd0, 32'hF800_0000);
        vecs[6]  = mk(ALU_SHIFT,     LOGIC_XOR, 6'b000000, 32'h8000_0000,  32'd4,          32'd0,          32'd0, 32'h0800_0000);
        vecs[7]  = mk(ALU_SHIFT,     LOGIC_XOR, 6'b000100, 32'd1,          32'h23,         32'd0,          32'd0, 32'd8);
        vecs[8]  = mk(ALU_SLT_LOGIC, LOGIC_XOR, 6'b000000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0,          32'd0, 32'h0FF0_0FF0);
        vecs[9]  = mk(ALU_SLT_LOGIC, LOGIC_OR,  6'b000000, 32'hA0,         32'h05,         32'd0,          32'd0, 32'hA5);
        vecs[10] = mk(ALU_SLT_LOGIC, LOGIC_AND, 6'b000000, 32'h1234_5678,  32'h0000_FFFF,  32'd0,          32'd0, 32'h5678);
        vecs[11] = mk(ALU_CONSTANT,  LOGIC_XOR, 6'b000000, 32'd1,          32'd2,          32'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        vecs[12] = mk(ALU_SLT_LOGIC, LOGIC_XOR, 6'b110000, 32'd3,          32'd5,          32'd0,          32'd0, 32'd1);
        vecs[13] = mk(ALU_SLT_LOGIC, LOGIC_XOR, 6'b111000, 32'd0,          32'hFFFF_FFFF,  32'd0,          32'd0, 32'd1);

        rst = 1'b1; v32 = 1'b0; v64 = 1'b0; ack32 = 1'b0; ack64 = 1'b1; id = 3'd0;
        set_ctrl(ALU_ADD_SUB, LOGIC_XOR, 6'b000000, 64'd0, 64'd0, 64'd0, 64'd0);
`ifdef ALU_SHADD_EN
        shadd_amt = 2'd0;
`endif
        repeat (3) tk();
        rst = 1'b0;
        tk();
        chk("rst_done32",  {63'd0, done32},  64'd0);
        chk("rst_id32",    {61'd0, wid32},   64'd0);
        chk("rst_rd32",    {32'd0, wrd32},   64'd0);
        chk("rst_ready32", {63'd0, ready32}, 64'd1);
        chk("rst_done64",  {63'd0, done64},  64'd0);
        chk("rst_ready64", {63'd0, ready64}, 64'd1);

        // Latency: accept cycle counts as cycle 0, wb_done expected in cycle 3.
        ack32 = 1'b1;
        set_ctrl(ALU_ADD_SUB, LOGIC_XOR, 6'b000000, 64'd5, 64'd7, 64'd0, 64'd0);
        id = 3'd1; v32 = 1'b1;
        tk();
        v32 = 1'b0;
        chk("lat_c1", {63'd0, done32}, 64'd0);
        tk();
        chk("lat_c2", {63'd0, done32}, 64'd0);
        tk();
        chk("lat_c3", {63'd0, done32}, 64'd1);
        chk("lat_rd", {32'd0, wrd32},  64'd12);
        chk("lat_id", {61'd0, wid32},  64'd1);
        tk();
        chk("lat_popped", {63'd0, done32}, 64'd0);

        for (int i = 0; i < 14; i++) begin
            set_ctrl(vecs[i].op, vecs[i].lop, vecs[i].flags, {32'd0, vecs[i].rs1},
                     {32'd0, vecs[i].rs2}, {32'd0, vecs[i].imm}, {32'd0, vecs[i].cst});
            run32($sformatf("vec%0d", i), vecs[i].exp, 3'(i));
        end

`ifdef ALU_SHADD_EN
        set_ctrl(ALU_SHADD, LOGIC_XOR, 6'b000000, 64'd2, 64'd1, 64'd0, 64'd0);
        shadd_amt = 2'd3;
        run32("shadd3", 32'd17, 3'd2);
        shadd_amt = 2'd0;
`else
        set_ctrl(ALU_SHADD, LOGIC_XOR, 6'b000000, 64'd2, 64'd1, 64'd0, 64'd0);
        run32("shadd_as_add", 32'd3, 3'd2);
`endif

        // Backpressure: fill all credits with no writeback, then drain in order.
        ack32 = 1'b0;
        got.delete();
        for (int k = 0; k < 4; k++) begin
            set_ctrl(ALU_ADD_SUB, LOGIC_XOR, 6'b000000, 64'(k), 64'd0, 64'd0, 64'd0);
            id = 3'(k); v32 = 1'b1;
            tk();
            if (k == 2) chk("ready_at3", {63'd0, ready32}, 64'd1);
        end
        chk("full_ready", {63'd0, ready32}, 64'd0);
        set_ctrl(ALU_ADD_SUB, LOGIC_XOR, 6'b000000, 64'd4, 64'd0, 64'd0, 64'd0);
        id = 3'd4;
        repeat (3) tk();
        chk("full_hold",   {63'd0, ready32}, 64'd0);
        chk("head_done",   {63'd0, done32},  64'd1);
        chk("head_stable", {61'd0, wid32},   64'd0);
        chk("head_rd",     {32'd0, wrd32},   64'd0);
        ack32 = 1'b1;
        tk();
        ack32 = 1'b0;
        chk("ready_after_ack", {63'd0, ready32}, 64'd1);
        ack32 = 1'b1;
        tk();
        v32 = 1'b0;
        chk("ack_issue_same", {63'd0, ready32}, 64'd1);
        for (int w = 0; w < 20 && got.size() < 5; w++) tk();
        chk("order_count", 64'(got.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got.size()) chk($sformatf("order%0d", k), {61'd0, got[k]}, 64'(k));
        end

        // Reset with two ops in the stages and one buffered.
        ack32 = 1'b0;
        for (int k = 5; k < 8; k++) begin
            set_ctrl(ALU_CONSTANT, LOGIC_XOR, 6'b000000, 64'd0, 64'd0, 64'd0, 64'(k));
            id = 3'(k); v32 = 1'b1;
            tk();
        end
        v32 = 1'b0;
        chk("pre_rst_done", {63'd0, done32}, 64'd1);
        rst = 1'b1;
        tk();
        rst = 1'b0;
        chk("mid_rst_done",  {63'd0, done32},  64'd0);
        chk("mid_rst_ready", {63'd0, ready32}, 64'd1);
        chk("mid_rst_id",    {61'd0, wid32},   64'd0);
        chk("mid_rst_rd",    {32'd0, wrd32},   64'd0);
        for (int k = 0; k < 4; k++) begin
            tk();
            chk($sformatf("no_stale%0d", k), {63'd0, done32}, 64'd0);
        end
        ack32 = 1'b1;
        set_ctrl(ALU_ADD_SUB, LOGIC_XOR, 6'b100000, 64'd9, 64'd4, 64'd0, 64'd0);
        run32("post_rst", 32'd5, 3'd3);

        set_ctrl(ALU_ADD_SUB, LOGIC_XOR, 6'b000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
        run64("x64_add_wrap", 64'd0);
        set_ctrl(ALU_ADD_SUB, LOGIC_XOR, 6'b000000, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
        run64("x64_add_carry32", 64'h1_0000_0000);
        set_ctrl(ALU_SHIFT, LOGIC_XOR, 6'b000100, 64'd1, 64'd104, 64'd0, 64'd0);
        run64("x64_sll40", 64'h0000_0100_0000_0000);
        set_ctrl(ALU_SHIFT, LOGIC_XOR, 6'b000010, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0);
        run64("x64_sra4", 64'hF800_0000_0000_0000);
        set_ctrl(ALU_SLT_LOGIC, LOGIC_XOR, 6'b110000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
        run64("x64_slt", 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
